// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the pipeline boundary registers
//
// occ_t      : 2-bit entry count (0..2) held by a skid register
// mem_wb_t   : MEM/WB payload; its packed width is the default DATA_W
package pipe_pkg;

    typedef logic [1:0] occ_t;

    typedef struct packed {
        logic [31:0] ram_data;
        logic [31:0] alu_result;
        logic [4:0]  rd;
        logic        reg_write;
        logic [31:0] next_pc;
    } mem_wb_t;

    localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
//
// clk   : clock, rising edge
// reset : synchronous active-high clear
// inc   : add one this cycle (ignored once at all-ones)
// count : current value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_skid_register.sv
// rtl/pipeline_skid_register.sv - two-entry skid register for a pipeline boundary
//
// clk, reset           : clock and synchronous active-high reset
// in_valid/in_ready    : upstream handshake, in_data payload
// out_valid/out_ready  : downstream handshake, out_data payload
// flush                : drop held and incoming payloads
// occupancy            : entries held (0..2)
// stall_cnt            : saturating count of cycles with out_valid && !out_ready
module pipeline_skid_register
    import pipe_pkg::*;
#(
    parameter int DATA_W         = MEM_WB_W,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output occ_t              occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic rel;
    logic main_valid_n;
    logic skid_valid_n;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign accept    = in_valid && in_ready;
    assign rel       = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // in_ready is registered as "skid will be empty", so an accept can never
    // coincide with a skid->main move and out_ready never reaches in_ready
    // combinationally.
    always_comb begin
        main_valid_n   = main_valid;
        skid_valid_n   = skid_valid;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (rel && skid_valid) begin
            load_main_skid = 1'b1;
            skid_valid_n   = 1'b0;
        end else if (rel) begin
            main_valid_n = accept;
            load_main_in = accept;
        end else if (accept) begin
            if (main_valid) begin
                load_skid    = 1'b1;
                skid_valid_n = 1'b1;
            end else begin
                load_main_in = 1'b1;
                main_valid_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
            in_ready   <= 1'b1;
            occupancy  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            if (CLEAR_ON_FLUSH) begin
                main_data <= '0;
                skid_data <= '0;
            end
            in_ready  <= 1'b1;
            occupancy <= '0;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            if (load_main_skid) begin
                main_data <= skid_data;
            end else if (load_main_in) begin
                main_data <= in_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
            in_ready  <= !skid_valid_n;
            occupancy <= {1'b0, main_valid_n} + {1'b0, skid_valid_n};
        end
    end

    // Back-pressure is counted even in a flush cycle; only reset clears it.
    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (main_valid && !out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipeline_skid_register.sv
// tb/tb_pipeline_skid_register.sv - directed table-driven bench for pipeline_skid_register
module tb_pipeline_skid_register;

    localparam int DW = 102;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          flush;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    logic          in_ready2, out_valid2;
    logic [15:0]   out_data2;
    logic [1:0]    occupancy2;
    logic [3:0]    stall_cnt2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_skid_register #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipeline_skid_register #(.DATA_W(16), .CLEAR_ON_FLUSH(1'b0), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data[15:0]), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .flush(flush), .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    typedef struct {
        logic          rst;
        logic          fl;
        logic          iv;
        logic          ordy;
        logic [DW-1:0] d;
        logic          eov;
        logic          eir;
        logic [DW-1:0] eod;
        logic [1:0]    eocc;
        logic [15:0]   esc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic fl, logic iv, logic ordy, logic [DW-1:0] d,
                                logic eov, logic eir, logic [DW-1:0] eod, logic [1:0] eocc,
                                logic [15:0] esc);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.d = d;
        v.eov = eov; v.eir = eir; v.eod = eod; v.eocc = eocc; v.esc = esc;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic fl, logic iv, logic ordy, logic [DW-1:0] d);
        reset = rst; flush = fl; in_valid = iv; out_ready = ordy; in_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        //              rst fl iv or data   ov ir out   occ sc
        vecs.push_back(mk(1, 0, 1, 0, 'h55, 0, 1, 'h0,  0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 'h55, 0, 1, 'h0,  0, 0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 0, 1, 1, i, 1, 1, i, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'h0,  0, 1, 'h8,  0, 0));
        // back-pressure: A to main, B to skid, C held upstream
        vecs.push_back(mk(0, 0, 1, 0, 'hA,  1, 1, 'hA,  1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 'hB,  1, 0, 'hA,  2, 1));
        vecs.push_back(mk(0, 0, 1, 0, 'hC,  1, 0, 'hA,  2, 2));
        vecs.push_back(mk(0, 0, 1, 1, 'hC,  1, 1, 'hB,  1, 2));
        vecs.push_back(mk(0, 0, 1, 1, 'hC,  1, 1, 'hC,  1, 2));
        vecs.push_back(mk(0, 0, 0, 1, 'h0,  0, 1, 'hC,  0, 2));
        // fill to two entries then flush with 0xD incoming
        vecs.push_back(mk(0, 0, 1, 0, 'hE,  1, 1, 'hE,  1, 2));
        vecs.push_back(mk(0, 0, 1, 0, 'hF,  1, 0, 'hE,  2, 3));
        vecs.push_back(mk(0, 1, 1, 0, 'hD,  0, 1, 'h0,  0, 4));
        vecs.push_back(mk(0, 0, 0, 1, 'h0,  0, 1, 'h0,  0, 4));
        vecs.push_back(mk(0, 0, 1, 1, 'h11, 1, 1, 'h11, 1, 4));
        vecs.push_back(mk(0, 0, 0, 1, 'h0,  0, 1, 'h11, 0, 4));
        // reset mid-transfer beats flush, then accept on first free cycle
        vecs.push_back(mk(0, 0, 1, 0, 'h22, 1, 1, 'h22, 1, 4));
        vecs.push_back(mk(0, 0, 1, 0, 'h33, 1, 0, 'h22, 2, 5));
        vecs.push_back(mk(1, 1, 1, 0, 'h44, 0, 1, 'h0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 'h55, 1, 1, 'h55, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'h0,  0, 1, 'h55, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].d);
            chk("out_valid", i, 128'(out_valid), 128'(vecs[i].eov));
            chk("in_ready",  i, 128'(in_ready),  128'(vecs[i].eir));
            chk("out_data",  i, 128'(out_data),  128'(vecs[i].eod));
            chk("occupancy", i, 128'(occupancy), 128'(vecs[i].eocc));
            chk("stall_cnt", i, 128'(stall_cnt), 128'(vecs[i].esc));
        end

        // payloads survive a flush when clearing is disabled
        drive(1, 0, 0, 0, 'h0);
        drive(0, 0, 1, 0, 'h77);
        drive(0, 0, 1, 0, 'h88);
        chk("occ2_full", 100, 128'(occupancy2), 128'(2));
        drive(0, 1, 1, 0, 'h99);
        chk("flush_keep_data", 101, 128'(out_data2), 128'(16'h77));
        chk("flush_keep_valid", 102, 128'(out_valid2), 128'(0));
        chk("flush_keep_occ", 103, 128'(occupancy2), 128'(0));
        chk("flush_clear_data", 104, 128'(out_data), 128'(0));
        drive(0, 0, 1, 1, 'h66);
        chk("post_flush_data", 105, 128'(out_data2), 128'(16'h66));

        // saturation: 4-bit counter pinned at 15, 16-bit counter keeps going
        drive(1, 0, 0, 0, 'h0);
        drive(0, 0, 1, 0, 'h1);
        for (int c = 0; c < 20; c++) begin
            drive(0, 0, 0, 0, 'h0);
            if (c == 14) chk("sat_reach", 200, 128'(stall_cnt2), 128'(15));
        end
        chk("sat_hold", 201, 128'(stall_cnt2), 128'(15));
        chk("wide_cnt", 202, 128'(stall_cnt), 128'(20));
        chk("sat_data", 203, 128'(out_data), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
